// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and state encoding for the IF/ID sequencing controller
// and its mult/div occupancy timer.
package pipe_ctrl_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam int          REG_ZERO = 0;
    localparam logic [31:0] NOP      = 32'h0000_0000;

endpackage

// File: rtl/muldiv_timer.sv
// Occupancy timer for the multi-cycle mult/div unit: busy for exactly LAT
// cycles after each accepted start.
module muldiv_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int LAT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy
);

    md_state_e  state, state_nxt;
    logic [7:0] count, count_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MD_IDLE;
            count <= 8'd0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // A start while BUSY is impossible upstream (it stalls), so it is ignored here.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    state_nxt = MD_BUSY;
                    count_nxt = 8'(LAT);
                end
            end
            MD_BUSY: begin
                if (count == 8'd1) begin
                    state_nxt = MD_IDLE;
                    count_nxt = 8'd0;
                end else begin
                    count_nxt = count - 8'd1;
                end
            end
            default: begin
                state_nxt = MD_IDLE;
                count_nxt = 8'd0;
            end
        endcase
    end

    assign busy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// IF/ID sequencing: decides advance/hold/flush of PC and IF/ID, ID/EX bubbles,
// times the mult/div unit and counts stalled cycles.
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULDIV_LAT = 32,
    parameter int REG_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             id_branch_taken,
    input  logic             id_muldiv,
    input  logic             id_reads_hilo,
    input  logic             imem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             muldiv_start,
    output logic             muldiv_busy,
    output logic [31:0]      stall_cycles
);

    logic        load_use;
    logic        md_hazard;
    logic        stall_id;
    logic [31:0] stall_cnt;

    // A load into r0 never produces a usable value, so it never stalls.
    assign load_use  = ex_memread && (ex_rt != REG_W'(REG_ZERO)) &&
                       ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign md_hazard = muldiv_busy && (id_muldiv || id_reads_hilo);
    assign stall_id  = load_use || md_hazard;

    // Stall wins over a branch redirect; the branch is seen again next cycle.
    assign pc_write     = !stall_id && (imem_ready || id_branch_taken);
    assign ifid_write   = !stall_id;
    assign ifid_flush   = !stall_id && (id_branch_taken || !imem_ready);
    assign idex_bubble  = stall_id;
    assign muldiv_start = id_muldiv && !stall_id;

    muldiv_timer #(
        .LAT (MULDIV_LAT)
    ) u_muldiv_timer (
        .clk   (clk),
        .rst   (rst),
        .start (muldiv_start),
        .busy  (muldiv_busy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (stall_id && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus randomized traffic
// against a remaining-busy-cycles / saturating-count reference model.
module tb_hazard_stall_ctrl;

    localparam int LAT   = 4;
    localparam int REG_W = 5;

    logic             clk;
    logic             rst;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             ex_memread;
    logic [REG_W-1:0] ex_rt;
    logic             id_branch_taken;
    logic             id_muldiv;
    logic             id_reads_hilo;
    logic             imem_ready;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             muldiv_start;
    logic             muldiv_busy;
    logic [31:0]      stall_cycles;

    int      n_cmp = 0;
    int      n_err = 0;
    int      md_rem;       // cycles of mult/div occupancy still to come
    longint  stall_exp;    // expected stall count

    hazard_stall_ctrl #(
        .MULDIV_LAT (LAT),
        .REG_W      (REG_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_memread      (ex_memread),
        .ex_rt           (ex_rt),
        .id_branch_taken (id_branch_taken),
        .id_muldiv       (id_muldiv),
        .id_reads_hilo   (id_reads_hilo),
        .imem_ready      (imem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .muldiv_start    (muldiv_start),
        .muldiv_busy     (muldiv_busy),
        .stall_cycles    (stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic set_idle();
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
        ex_memread = 1'b0; ex_rt = '0;
        id_branch_taken = 1'b0; id_muldiv = 1'b0; id_reads_hilo = 1'b0;
        imem_ready = 1'b1;
    endtask

    // Advance one clock; the model consumes the inputs present before the edge.
    task automatic tick();
        bit busy_m, lu, st, start;
        busy_m = (md_rem > 0);
        lu = ex_memread && (ex_rt != 0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        st = lu || (busy_m && (id_muldiv || id_reads_hilo));
        start = id_muldiv && !st;
        @(posedge clk);
        if (st && stall_exp < 64'hFFFF_FFFF) stall_exp++;
        if (md_rem > 0) md_rem--;
        else if (start) md_rem = LAT;
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        md_rem = 0;
        stall_exp = 0;
        #2;
        n_cmp++;
        if (muldiv_busy !== 1'b0 || stall_cycles !== 32'd0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b cnt=%h required busy=0 cnt=0", muldiv_busy, stall_cycles);
        end
        n_cmp++;
        if ({pc_write, ifid_write, ifid_flush, idex_bubble, muldiv_start} !== 5'b11000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b required 11000",
                     {pc_write, ifid_write, ifid_flush, idex_bubble, muldiv_start});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        set_idle();
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        #3;
        n_cmp++;
        if ({pc_write, ifid_write, idex_bubble} !== 3'b001) begin
            n_err++;
            $display("FAIL load_use_stall: pc/ifid/bubble=%b required 001", {pc_write, ifid_write, idex_bubble});
        end
        tick();
        n_cmp++;
        if (stall_cycles !== 32'd1) begin
            n_err++;
            $display("FAIL load_use_count: got %0d required 1", stall_cycles);
        end
        ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
        #3;
        n_cmp++;
        if ({pc_write, ifid_write, idex_bubble} !== 3'b110) begin
            n_err++;
            $display("FAIL load_r0_nostall: pc/ifid/bubble=%b required 110", {pc_write, ifid_write, idex_bubble});
        end
        ex_rt = 5'd3; id_rs = 5'd1; id_rt = 5'd3; id_uses_rt = 1'b0;
        #1;
        n_cmp++;
        if (idex_bubble !== 1'b0) begin
            n_err++;
            $display("FAIL rt_unused_nostall: bubble=%b required 0", idex_bubble);
        end
        id_uses_rt = 1'b1;
        #1;
        n_cmp++;
        if (idex_bubble !== 1'b1) begin
            n_err++;
            $display("FAIL rt_used_stall: bubble=%b required 1", idex_bubble);
        end
        tick();
        set_idle();
    endtask

    task automatic test_muldiv();
        set_idle();
        id_muldiv = 1'b1;
        #3;
        n_cmp++;
        if (muldiv_start !== 1'b1 || muldiv_busy !== 1'b0) begin
            n_err++;
            $display("FAIL md_start: start=%b busy=%b required 1 0", muldiv_start, muldiv_busy);
        end
        tick();
        id_muldiv = 1'b0;
        id_reads_hilo = 1'b1;
        for (int i = 1; i <= LAT; i++) begin
            #3;
            n_cmp++;
            if (muldiv_busy !== 1'b1 || idex_bubble !== 1'b1 || pc_write !== 1'b0) begin
                n_err++;
                $display("FAIL md_busy_cycle%0d: busy=%b bubble=%b pc=%b required 1 1 0",
                         i, muldiv_busy, idex_bubble, pc_write);
            end
            tick();
        end
        #3;
        n_cmp++;
        if (muldiv_busy !== 1'b0 || idex_bubble !== 1'b0 || pc_write !== 1'b1) begin
            n_err++;
            $display("FAIL md_release: busy=%b bubble=%b pc=%b required 0 0 1",
                     muldiv_busy, idex_bubble, pc_write);
        end
        n_cmp++;
        if (stall_cycles !== stall_exp[31:0]) begin
            n_err++;
            $display("FAIL md_count: got %0d required %0d", stall_cycles, stall_exp);
        end
        tick();
        set_idle();
    endtask

    task automatic test_branch();
        set_idle();
        id_branch_taken = 1'b1; imem_ready = 1'b0;
        #3;
        n_cmp++;
        if ({pc_write, ifid_write, ifid_flush} !== 3'b111) begin
            n_err++;
            $display("FAIL branch_miss: pc/ifid/flush=%b required 111", {pc_write, ifid_write, ifid_flush});
        end
        imem_ready = 1'b0; id_branch_taken = 1'b0;
        #1;
        n_cmp++;
        if ({pc_write, ifid_write, ifid_flush} !== 3'b011) begin
            n_err++;
            $display("FAIL imem_miss: pc/ifid/flush=%b required 011", {pc_write, ifid_write, ifid_flush});
        end
        tick();
        set_idle();
        id_branch_taken = 1'b1;
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #3;
        n_cmp++;
        if ({pc_write, ifid_write, ifid_flush} !== 3'b000) begin
            n_err++;
            $display("FAIL branch_stalled: pc/ifid/flush=%b required 000", {pc_write, ifid_write, ifid_flush});
        end
        tick();
        ex_memread = 1'b0;
        #3;
        n_cmp++;
        if ({pc_write, ifid_write, ifid_flush} !== 3'b111) begin
            n_err++;
            $display("FAIL branch_retry: pc/ifid/flush=%b required 111", {pc_write, ifid_write, ifid_flush});
        end
        tick();
        set_idle();
    endtask

    task automatic test_reset_mid_busy();
        set_idle();
        id_muldiv = 1'b1;
        tick();
        id_muldiv = 1'b0;
        tick();
        tick();
        #3;
        rst = 1'b1;
        md_rem = 0;
        stall_exp = 0;
        #1;
        n_cmp++;
        if (muldiv_busy !== 1'b0 || stall_cycles !== 32'd0) begin
            n_err++;
            $display("FAIL rst_mid_busy: busy=%b cnt=%h required 0 0", muldiv_busy, stall_cycles);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        id_muldiv = 1'b1;
        tick();
        id_muldiv = 1'b0;
        for (int i = 1; i <= LAT + 1; i++) begin
            #3;
            n_cmp++;
            if (muldiv_busy !== (i <= LAT)) begin
                n_err++;
                $display("FAIL restart_window%0d: busy=%b required %b", i, muldiv_busy, (i <= LAT));
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        set_idle();
        #3;
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt;
        stall_exp = 64'hFFFF_FFFE;
        ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
        for (int i = 0; i < 3; i++) begin
            tick();
            #3;
            n_cmp++;
            if (stall_cycles !== 32'hFFFF_FFFF) begin
                n_err++;
                $display("FAIL saturate%0d: got %h required ffffffff", i, stall_cycles);
            end
        end
        set_idle();
        tick();
        rst = 1'b1;
        md_rem = 0;
        stall_exp = 0;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        bit busy_m, lu, st;
        logic [6:0] exp_v, got_v;
        for (int c = 0; c < 500; c++) begin
            id_rs = REG_W'($urandom_range(0, 3));
            id_rt = REG_W'($urandom_range(0, 3));
            ex_rt = REG_W'($urandom_range(0, 3));
            id_uses_rt = 1'($urandom_range(0, 1));
            ex_memread = ($urandom_range(0, 2) == 0);
            id_branch_taken = ($urandom_range(0, 3) == 0);
            id_muldiv = ($urandom_range(0, 9) == 0);
            id_reads_hilo = ($urandom_range(0, 3) == 0);
            imem_ready = ($urandom_range(0, 3) != 0);
            #3;
            busy_m = (md_rem > 0);
            lu = ex_memread && (ex_rt != 0) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
            st = lu || (busy_m && (id_muldiv || id_reads_hilo));
            exp_v = {!st && (imem_ready || id_branch_taken), !st,
                     !st && (id_branch_taken || !imem_ready), st,
                     id_muldiv && !st, busy_m, 1'b0};
            got_v = {pc_write, ifid_write, ifid_flush, idex_bubble,
                     muldiv_start, muldiv_busy, 1'b0};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL rand_outputs c=%0d: got %b required %b", c, got_v, exp_v);
            end
            n_cmp++;
            if (stall_cycles !== stall_exp[31:0]) begin
                n_err++;
                $display("FAIL rand_count c=%0d: got %0d required %0d", c, stall_cycles, stall_exp);
            end
            tick();
        end
        set_idle();
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        md_rem = 0;
        stall_exp = 0;
        test_reset();
        test_load_use();
        test_muldiv();
        test_branch();
        test_reset_mid_busy();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
